// File: rtl/bist_fail_log_pkg.sv
// Shared types and helpers for the BIST failure logger.
//   state_t  : logger control states (IDLE, ARM, RUN, DONE)
//   entry_t  : one logged failure {addr, exp, act} at the default SRAM widths
//   sat_inc  : saturating increment used by the failure counter
package bist_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] act;
    } entry_t;

    // Increment that sticks at max_value; counter widths up to 31 bits fit.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/bist_fail_log_fail_fifo.sv
// fail_fifo: DEPTH-entry synchronous FIFO holding packed failure records.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : synchronous flush (same effect as rst on the pointers)
//   push, din : write din when not full
//   pop       : advance the head when not empty
//   head      : entry at the read pointer (first-word fall-through)
//   full/empty: occupancy flags
module fail_fifo
    import bist_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates the full and empty cases when the
    // index bits are equal.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic do_push_s;
    logic do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer registers, flushed by reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents beyond the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst && !clear) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bist_fail_log.sv
// bist_fail_log: captures BIST compare failures during a run, counts them
// (saturating) and replays the captured log over a valid/ready port.
//   clk, rst                      : clock, synchronous active-high reset
//   start                         : arms the logger and clears the last record
//   NbarT                         : 1 while BIST is running
//   fail, fail_addr, expected,
//   actual                        : per-cycle compare result and its context
//   out_valid/out_ready,
//   out_addr/out_exp/out_act      : log readout, head entry shown directly
//   fail_count                    : failures this run, saturating
//   overflow                      : sticky, a failure found the log full
//   done, pass                    : run finished / finished with no failures
module bist_fail_log
    import bist_pkg::*;
#(
    parameter int size   = 6,
    parameter int length = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              NbarT,
    input  logic              fail,
    input  logic [size-1:0]   fail_addr,
    input  logic [length-1:0] expected,
    input  logic [length-1:0] actual,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [size-1:0]   out_addr,
    output logic [length-1:0] out_exp,
    output logic [length-1:0] out_act,
    output logic [CNT_W-1:0]  fail_count,
    output logic              overflow,
    output logic              done,
    output logic              pass
);

    localparam int          EW      = size + 2 * length;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t            state_r;
    state_t            next_s;
    logic [CNT_W-1:0]  fail_count_r;
    logic              overflow_r;
    logic              done_r;

    logic              capture_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [EW-1:0]     din_s;
    logic [EW-1:0]     head_s;

    // The capture decision looks at the registered state, so a fail on the
    // edge where NbarT drops is still logged. start wins over everything.
    assign capture_s = (state_r == RUN) && fail && !start;
    assign pop_s     = out_valid && out_ready && !start;
    assign din_s     = {fail_addr, expected, actual};

    fail_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .push  (capture_s),
        .pop   (pop_s),
        .din   (din_s),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; start re-arms from any state.
    always_comb begin
        next_s = state_r;
        if (start) begin
            next_s = ARM;
        end else begin
            case (state_r)
                IDLE: next_s = IDLE;
                ARM:  next_s = NbarT ? RUN : ARM;
                RUN:  next_s = NbarT ? RUN : DONE;
                DONE: next_s = DONE;
                default: next_s = IDLE;
            endcase
        end
    end

    // Saturating failure counter, cleared on arm.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            fail_count_r <= '0;
        end else if ((state_r == RUN) && fail) begin
            fail_count_r <= CNT_W'(sat_inc(32'(fail_count_r), CNT_MAX));
        end
    end

    // Sticky overflow flag: a failure arrived while the log was full.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            overflow_r <= 1'b0;
        end else if (capture_s && full_s) begin
            overflow_r <= 1'b1;
        end
    end

    // done rises on the edge leaving RUN and holds until the next arm.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            done_r <= 1'b0;
        end else if ((state_r == RUN) && !NbarT) begin
            done_r <= 1'b1;
        end
    end

    // Readout gating: the data lines read zero whenever nothing is offered.
    always_comb begin
        out_valid = done_r && !empty_s;
        if (out_valid) begin
            out_addr = head_s[EW-1 -: size];
            out_exp  = head_s[2*length-1 -: length];
            out_act  = head_s[length-1:0];
        end else begin
            out_addr = {size{1'b0}};
            out_exp  = {length{1'b0}};
            out_act  = {length{1'b0}};
        end
    end

    assign fail_count = fail_count_r;
    assign overflow   = overflow_r;
    assign done       = done_r;
    assign pass       = done_r && (fail_count_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_bist_fail_log.sv
// Self-checking bench for bist_fail_log: a hand-computed vector table, a few
// directed multi-cycle sequences and randomized runs, all checked against a
// queue-based reference model. A second instance with CNT_W=3 covers
// counter saturation.
module tb_bist_fail_log;
    import bist_pkg::*;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, nbart, fail, out_ready;
    logic [5:0] fail_addr;
    logic [7:0] expected, actual;

    logic       out_valid, overflow, done, pass;
    logic [5:0] out_addr;
    logic [7:0] out_exp, out_act;
    logic [9:0] fail_count;

    logic       s_out_valid, s_overflow, s_done, s_pass;
    logic [5:0] s_out_addr;
    logic [7:0] s_out_exp, s_out_act;
    logic [2:0] s_fail_count;

    bist_fail_log dut (
        .clk(clk), .rst(rst), .start(start), .NbarT(nbart), .fail(fail),
        .fail_addr(fail_addr), .expected(expected), .actual(actual),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_exp(out_exp), .out_act(out_act), .fail_count(fail_count),
        .overflow(overflow), .done(done), .pass(pass)
    );

    bist_fail_log #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start), .NbarT(nbart), .fail(fail),
        .fail_addr(fail_addr), .expected(expected), .actual(actual),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr),
        .out_exp(s_out_exp), .out_act(s_out_act), .fail_count(s_fail_count),
        .overflow(s_overflow), .done(s_done), .pass(s_pass)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    entry_t m_q[$];
    int     m_phase;
    int     m_cnt;
    bit     m_ovf;
    bit     m_done;

    typedef struct {
        logic       s, n, f;
        logic [5:0] a;
        logic [7:0] e, x;
        logic       r;
        logic       ev;
        logic [5:0] ea;
        logic [7:0] ee, ex;
        logic [9:0] ec;
        logic       eo, ed, ep;
    } vec_t;

    vec_t tbl[9];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic set_in(input logic s, input logic n, input logic f,
                          input logic [5:0] a, input logic [7:0] e,
                          input logic [7:0] x, input logic r);
        start = s; nbart = n; fail = f;
        fail_addr = a; expected = e; actual = x; out_ready = r;
    endtask

    task automatic model_update();
        if (rst) begin
            m_q.delete(); m_cnt = 0; m_ovf = 0; m_done = 0; m_phase = PH_IDLE;
        end else if (start) begin
            m_q.delete(); m_cnt = 0; m_ovf = 0; m_done = 0; m_phase = PH_ARM;
        end else begin
            case (m_phase)
                PH_ARM: if (nbart) m_phase = PH_RUN;
                PH_RUN: begin
                    if (fail) begin
                        if (m_cnt < 1023) m_cnt++;
                        if (m_q.size() < 4) m_q.push_back('{fail_addr, expected, actual});
                        else m_ovf = 1;
                    end
                    if (!nbart) begin
                        m_done = 1; m_phase = PH_DONE;
                    end
                end
                PH_DONE: if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        logic   ev;
        entry_t h;
        ev = m_done && (m_q.size() > 0);
        h  = ev ? m_q[0] : '0;
        cmp("out_valid",  32'(out_valid),  32'(ev));
        cmp("out_addr",   32'(out_addr),   32'(h.addr));
        cmp("out_exp",    32'(out_exp),    32'(h.exp));
        cmp("out_act",    32'(out_act),    32'(h.act));
        cmp("fail_count", 32'(fail_count), 32'(m_cnt));
        cmp("overflow",   32'(overflow),   32'(m_ovf));
        cmp("done",       32'(done),       32'(m_done));
        cmp("pass",       32'(pass),       32'(m_done && m_cnt == 0));
        cmp("sat_count",  32'(s_fail_count), 32'((m_cnt > 7) ? 7 : m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic s, input logic n, input logic f,
                                input logic [5:0] a, input logic [7:0] e,
                                input logic [7:0] x, input logic r,
                                input logic ev, input logic [5:0] ea,
                                input logic [7:0] ee, input logic [7:0] ex,
                                input logic [9:0] ec, input logic eo,
                                input logic ed, input logic ep);
        vec_t v;
        v.s = s; v.n = n; v.f = f; v.a = a; v.e = e; v.x = x; v.r = r;
        v.ev = ev; v.ea = ea; v.ee = ee; v.ex = ex; v.ec = ec;
        v.eo = eo; v.ed = ed; v.ep = ep;
        return v;
    endfunction

    initial begin
        // Two-failure run; row 1 carries a fail sampled in ARM (ignored).
        tbl[0] = mk(1'b1,1'b0,1'b0,6'h00,8'h00,8'h00,1'b0, 1'b0,6'h00,8'h00,8'h00,10'd0,1'b0,1'b0,1'b0);
        tbl[1] = mk(1'b0,1'b1,1'b1,6'h11,8'h11,8'h11,1'b0, 1'b0,6'h00,8'h00,8'h00,10'd0,1'b0,1'b0,1'b0);
        tbl[2] = mk(1'b0,1'b1,1'b1,6'h05,8'h20,8'h24,1'b0, 1'b0,6'h00,8'h00,8'h00,10'd1,1'b0,1'b0,1'b0);
        tbl[3] = mk(1'b0,1'b1,1'b0,6'h00,8'h00,8'h00,1'b0, 1'b0,6'h00,8'h00,8'h00,10'd1,1'b0,1'b0,1'b0);
        tbl[4] = mk(1'b0,1'b1,1'b1,6'h2A,8'h04,8'h00,1'b0, 1'b0,6'h00,8'h00,8'h00,10'd2,1'b0,1'b0,1'b0);
        tbl[5] = mk(1'b0,1'b0,1'b0,6'h00,8'h00,8'h00,1'b0, 1'b1,6'h05,8'h20,8'h24,10'd2,1'b0,1'b1,1'b0);
        tbl[6] = mk(1'b0,1'b0,1'b0,6'h00,8'h00,8'h00,1'b1, 1'b1,6'h2A,8'h04,8'h00,10'd2,1'b0,1'b1,1'b0);
        tbl[7] = mk(1'b0,1'b0,1'b0,6'h00,8'h00,8'h00,1'b1, 1'b0,6'h00,8'h00,8'h00,10'd2,1'b0,1'b1,1'b0);
        tbl[8] = mk(1'b0,1'b0,1'b1,6'h33,8'h33,8'h33,1'b1, 1'b0,6'h00,8'h00,8'h00,10'd2,1'b0,1'b1,1'b0);

        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Table-driven two-failure run
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].s, tbl[i].n, tbl[i].f, tbl[i].a, tbl[i].e, tbl[i].x, tbl[i].r);
            tick();
            cmp("tbl_valid", 32'(out_valid),  32'(tbl[i].ev));
            cmp("tbl_addr",  32'(out_addr),   32'(tbl[i].ea));
            cmp("tbl_exp",   32'(out_exp),    32'(tbl[i].ee));
            cmp("tbl_act",   32'(out_act),    32'(tbl[i].ex));
            cmp("tbl_count", 32'(fail_count), 32'(tbl[i].ec));
            cmp("tbl_ovf",   32'(overflow),   32'(tbl[i].eo));
            cmp("tbl_done",  32'(done),       32'(tbl[i].ed));
            cmp("tbl_pass",  32'(pass),       32'(tbl[i].ep));
        end

        // Clean run
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        for (int i = 0; i < 64; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        cmp("clean_done",  32'(done), 32'd1);
        cmp("clean_pass",  32'(pass), 32'd1);
        cmp("clean_count", 32'(fail_count), 32'd0);
        cmp("clean_valid", 32'(out_valid), 32'd0);

        // Overflow: six failures into a four-entry log
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        for (int i = 1; i <= 6; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 6'(i), 8'hA0, 8'(i), 1'b0); tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        cmp("ovf_count", 32'(fail_count), 32'd6);
        cmp("ovf_flag",  32'(overflow),   32'd1);
        cmp("ovf_pass",  32'(pass),       32'd0);
        for (int i = 1; i <= 4; i++) begin
            cmp("ovf_rd_valid", 32'(out_valid), 32'd1);
            cmp("ovf_rd_addr",  32'(out_addr),  32'(i));
            set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b1); tick();
        end
        cmp("ovf_rd_end", 32'(out_valid), 32'd0);
        cmp("ovf_keep",   32'(overflow),  32'd1);

        // Last-cycle capture plus backpressure
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b0, 1'b1, 6'h3F, 8'h5A, 8'hA5, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
            cmp("bp_valid", 32'(out_valid), 32'd1);
            cmp("bp_addr",  32'(out_addr),  32'h3F);
            cmp("bp_act",   32'(out_act),   32'hA5);
        end

        // Saturation (CNT_W=3 instance) with ten failures
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 6'(i), 8'h00, 8'hFF, 1'b0); tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        cmp("sat_final",  32'(s_fail_count), 32'd7);
        cmp("sat_wide",   32'(fail_count),   32'd10);

        // start during DONE with two entries pending and out_ready high
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 6'h0A, 8'h01, 8'h02, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 6'h0A, 8'h01, 8'h02, 1'b0); tick();
        set_in(1'b0, 1'b0, 1'b1, 6'h0B, 8'h03, 8'h04, 1'b0); tick();
        cmp("pre_start_valid", 32'(out_valid), 32'd1);
        set_in(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b1); tick();
        cmp("mid_start_valid", 32'(out_valid),  32'd0);
        cmp("mid_start_done",  32'(done),       32'd0);
        cmp("mid_start_count", 32'(fail_count), 32'd0);

        // Reset in the middle of a run
        set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 6'h12, 8'h34, 8'h56, 1'b0); tick();
        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b1, 6'h13, 8'h34, 8'h56, 1'b1); tick();
        rst = 1'b0;
        cmp("rst_count", 32'(fail_count), 32'd0);
        cmp("rst_done",  32'(done),       32'd0);
        cmp("rst_valid", 32'(out_valid),  32'd0);
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
        cmp("rst_idle_done", 32'(done), 32'd0);

        // Randomized runs
        for (int run = 0; run < 20; run++) begin
            set_in(1'b1, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            tick();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                set_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0);
                tick();
            end
            set_in(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0); tick();
            begin
                int len;
                len = int'($urandom_range(1, 30));
                for (int j = 0; j < len; j++) begin
                    set_in(1'b0, (j != len - 1), ($urandom_range(0, 9) < 3),
                           6'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                    tick();
                end
            end
            for (int j = 0; j < 12; j++) begin
                set_in(((run % 4) == 3) && (j == 5), 1'b0, 1'($urandom_range(0, 1)),
                       6'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
